// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: 2-bit branch history counter and its saturating update.
package rv32i_types;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_cnt_t;

   localparam bht_cnt_t BHT_RESET = WNT;

   function automatic bht_cnt_t bht_sat(input bht_cnt_t i_cnt, input logic i_taken);
      logic [1:0] w_raw;
      w_raw = i_cnt;
      if (i_taken) begin
         if (w_raw != 2'b11) w_raw = w_raw + 2'd1;
      end else begin
         if (w_raw != 2'b00) w_raw = w_raw - 2'd1;
      end
      return bht_cnt_t'(w_raw);
   endfunction

endpackage

// File: rtl/fetch_pc_unit_bht.sv
// Branch history table: 2^IDX_W two-bit saturating counters, combinational read,
// registered update (a same-index read in the update cycle sees the old value).
module bht_table
   import rv32i_types::*;
#(
   parameter int IDX_W = 6
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [IDX_W-1:0] i_rd_idx,
   output bht_cnt_t         o_rd_cnt,
   input  logic             i_upd_en,
   input  logic [IDX_W-1:0] i_upd_idx,
   input  logic             i_upd_taken
);

   localparam int N = 1 << IDX_W;

   bht_cnt_t r_cnt [N];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < N; i++) r_cnt[i] <= BHT_RESET;
      end else if (i_upd_en) begin
         r_cnt[i_upd_idx] <= bht_sat(r_cnt[i_upd_idx], i_upd_taken);
      end
   end

   assign o_rd_cnt = r_cnt[i_rd_idx];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator with BTB + 2-bit BHT direction prediction and EX-driven redirect.
// Optional FETCH_PERF_CNT_EN adds resolved-branch and mispredict counters.
module fetch_pc_unit
   import rv32i_types::*;
#(
   parameter logic [31:0] RESET_PC      = 32'h0000_0060,
   parameter int          BHT_IDX_WIDTH = 6
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stall,
   output logic [31:0] o_pc,
   output logic        o_pred_taken,
   output logic [31:0] o_pred_target,
   output logic        o_flush,
   output logic [31:0] o_btb_r_pc,
   output logic        o_btb_read,
   input  logic        i_btb_hit,
   input  logic [31:0] i_btb_target,
   output logic [31:0] o_btb_w_pc,
   output logic        o_btb_load,
   output logic [31:0] o_btb_target_in,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] o_perf_branches,
   output logic [31:0] o_perf_mispredicts,
`endif
   input  logic        i_res_valid,
   input  logic [31:0] i_res_pc,
   input  logic        i_res_taken,
   input  logic [31:0] i_res_target,
   input  logic        i_res_pred_taken,
   input  logic [31:0] i_res_pred_target
);

   logic [31:0] r_pc;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_next_pc;
   logic        w_pred_taken;
   logic        w_mispredict;
   bht_cnt_t    w_bht_cnt;

   bht_table #(.IDX_W(BHT_IDX_WIDTH)) u_bht (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_rd_idx   (r_pc[BHT_IDX_WIDTH+1:2]),
      .o_rd_cnt   (w_bht_cnt),
      .i_upd_en   (i_res_valid),
      .i_upd_idx  (i_res_pc[BHT_IDX_WIDTH+1:2]),
      .i_upd_taken(i_res_taken)
   );

   assign w_pc_plus4   = r_pc + 32'd4;
   assign w_pred_taken = i_btb_hit && w_bht_cnt[1];

   // A wrong target on a correctly-predicted taken branch still needs a redirect.
   assign w_mispredict = i_res_valid &&
                         ((i_res_taken != i_res_pred_taken) ||
                          (i_res_taken && (i_res_target != i_res_pred_target)));

   always_comb begin
      w_next_pc = w_pred_taken ? i_btb_target : w_pc_plus4;
      if (w_mispredict)  w_next_pc = i_res_taken ? i_res_target : (i_res_pc + 32'd4);
      else if (i_stall)  w_next_pc = r_pc;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_pc <= RESET_PC;
      else       r_pc <= w_next_pc;
   end

   assign o_pc            = r_pc;
   assign o_pred_taken    = w_pred_taken;
   assign o_pred_target   = w_pred_taken ? i_btb_target : w_pc_plus4;
   assign o_flush         = w_mispredict;
   assign o_btb_r_pc      = w_next_pc;
   assign o_btb_read      = w_mispredict || !i_stall;
   assign o_btb_load      = i_res_valid && i_res_taken;
   assign o_btb_w_pc      = i_res_pc;
   assign o_btb_target_in = i_res_target;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_br;
   logic [31:0] r_perf_mp;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_perf_br <= '0;
         r_perf_mp <= '0;
      end else begin
         if (i_res_valid)  r_perf_br <= r_perf_br + 32'd1;
         if (w_mispredict) r_perf_mp <= r_perf_mp + 32'd1;
      end
   end

   assign o_perf_branches    = r_perf_br;
   assign o_perf_mispredicts = r_perf_mp;
`endif

endmodule
